// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// and the select/ALU encodings that the datapath and ALUControl also decode.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that hold a memory request open until MemReady.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and MemReady in, all selects,
// strobes and status out.
interface mips_multicycle_control_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [5:0]             OpCode;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemToReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [2:0]             ALUOp;
  logic [1:0]             PCSource;
  logic [3:0]             State;
  logic [COUNT_WIDTH-1:0] InstrRetired;
  logic                   Fault;

  modport master (
    input  OpCode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
           InstrRetired, Fault
  );

  modport slave (
    output OpCode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
           InstrRetired, Fault
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on a slow shared memory, counts retired instructions, halts on faults.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input logic                      Clk,
  input logic                      Reset,
  mips_multicycle_control_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [7:0]             tmo_q, tmo_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   retire;
  logic                   tmo_expired;
  ctrl_t                  ctl;

  // This cycle is the last allowed wait; MemReady arriving now still wins.
  assign tmo_expired = !bus.MemReady && (tmo_q >= TMO_LAST);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.MemReady)     state_d = S_DECODE;
        else if (tmo_expired) state_d = S_HALT;
      end
      S_DECODE: begin
        case (bus.OpCode)
          OP_RTYPE: state_d = S_R_EXEC;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_I_EXEC;
          default:  state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.OpCode == OP_LW)      state_d = S_MEM_RD;
        else if (bus.OpCode == OP_SW) state_d = S_MEM_WR;
        else                          state_d = S_HALT;
      end
      S_MEM_RD: begin
        if (bus.MemReady)     state_d = S_MEM_WB;
        else if (tmo_expired) state_d = S_HALT;
      end
      S_MEM_WR: begin
        if (bus.MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (tmo_expired) begin
          state_d = S_HALT;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    tmo_d = '0;
    if (is_mem_wait(state_q) && !bus.MemReady && (state_d == state_q))
      tmo_d = tmo_q + 8'd1;
  end

  assign retired_d = retired_q + COUNT_WIDTH'(retire);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  // Moore decode on state; only the FETCH load strobes look at MemReady.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = bus.MemReady;
        ctl.pc_write  = bus.MemReady;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_BRANCH;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_I_WB: ctl.reg_write = 1'b1;
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_RT;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ctl = '0;
    endcase
  end

  assign bus.PCWrite      = ctl.pc_write;
  assign bus.PCWriteCond  = ctl.pc_write_cond;
  assign bus.IorD         = ctl.iord;
  assign bus.MemRead      = ctl.mem_read;
  assign bus.MemWrite     = ctl.mem_write;
  assign bus.IRWrite      = ctl.ir_write;
  assign bus.MemToReg     = ctl.mem_to_reg;
  assign bus.RegDst       = ctl.reg_dst;
  assign bus.RegWrite     = ctl.reg_write;
  assign bus.ALUSrcA      = ctl.alu_src_a;
  assign bus.ALUSrcB      = ctl.alu_src_b;
  assign bus.ALUOp        = ctl.alu_op;
  assign bus.PCSource     = ctl.pc_source;
  assign bus.State        = state_q;
  assign bus.InstrRetired = retired_q;
  assign bus.Fault        = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: directed per-cycle vectors push
// hand-written expectations; a negedge monitor pops and compares.
module tb_mips_multicycle_control;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mips_multicycle_control_if #(.COUNT_WIDTH(8)) bus ();

  mips_multicycle_control #(
    .MEM_TIMEOUT(4),
    .COUNT_WIDTH(8)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // Control word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //   MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], PCSource[1:0]}
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_000_00;
  localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_000_00;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_000_00;
  localparam logic [16:0] C_MEM_ADDR   = 17'b0_0_0_0_0_0_0_0_0_1_10_000_00;
  localparam logic [16:0] C_MEM_RD     = 17'b0_0_1_1_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] C_MEM_WB     = 17'b0_0_0_0_0_0_1_0_1_0_00_000_00;
  localparam logic [16:0] C_MEM_WR     = 17'b0_0_1_0_1_0_0_0_0_0_00_000_00;
  localparam logic [16:0] C_R_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_010_00;
  localparam logic [16:0] C_R_WB       = 17'b0_0_0_0_0_0_0_1_1_0_00_000_00;
  localparam logic [16:0] C_I_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_10_000_00;
  localparam logic [16:0] C_I_WB       = 17'b0_0_0_0_0_0_0_0_1_0_00_000_00;
  localparam logic [16:0] C_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_00_001_01;
  localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_000_10;
  localparam logic [16:0] C_HALT       = 17'b0;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4,
                         WR = 4'd5, RX = 4'd6, RW = 4'd7, BR = 4'd8, JP = 4'd9,
                         IX = 4'd10, IW = 4'd11, HT = 4'd15;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [7:0]  ret;
    logic        flt;
    logic [15:0] id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [16:0] act_ctl;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] step_id = 16'd0;

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [16:0] ctl,
                      input logic [7:0] ret, input logic flt);
    Reset        = rst;
    bus.OpCode   = op;
    bus.MemReady = rdy;
    sb.push_back('{st: st, ctl: ctl, ret: ret, flt: flt, id: step_id});
    step_id = step_id + 16'd1;
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      act_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.PCSource};
      checks = checks + 4;
      if (bus.State !== mon_e.st) begin
        errors = errors + 1;
        $display("FAIL state step %0d: got %0d expected %0d", mon_e.id, bus.State, mon_e.st);
      end
      if (act_ctl !== mon_e.ctl) begin
        errors = errors + 1;
        $display("FAIL ctrl step %0d: got %b expected %b", mon_e.id, act_ctl, mon_e.ctl);
      end
      if (bus.InstrRetired !== mon_e.ret) begin
        errors = errors + 1;
        $display("FAIL retired step %0d: got %0d expected %0d", mon_e.id, bus.InstrRetired, mon_e.ret);
      end
      if (bus.Fault !== mon_e.flt) begin
        errors = errors + 1;
        $display("FAIL fault step %0d: got %b expected %b", mon_e.id, bus.Fault, mon_e.flt);
      end
    end
  end

  initial begin
    Reset        = 1'b1;
    bus.OpCode   = 6'd0;
    bus.MemReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset state, then R-type: 0,1,6,7,0
    step(0, 6'h00, 0, FE, C_FETCH_WAIT, 8'd0, 0);
    step(0, 6'h00, 1, FE, C_FETCH_RDY,  8'd0, 0);
    step(0, 6'h00, 1, DE, C_DECODE,     8'd0, 0);
    step(0, 6'h00, 1, RX, C_R_EXEC,     8'd0, 0);
    step(0, 6'h00, 1, RW, C_R_WB,       8'd0, 0);

    // lw with three wait cycles in MEM_RD: 8 cycles total
    step(0, 6'h23, 1, FE, C_FETCH_RDY, 8'd1, 0);
    step(0, 6'h23, 1, DE, C_DECODE,    8'd1, 0);
    step(0, 6'h23, 0, MA, C_MEM_ADDR,  8'd1, 0);
    for (int i = 0; i < 3; i++) step(0, 6'h23, 0, MR, C_MEM_RD, 8'd1, 0);
    step(0, 6'h23, 1, MR, C_MEM_RD,    8'd1, 0);
    step(0, 6'h23, 0, MW, C_MEM_WB,    8'd1, 0);

    // sw with two wait cycles
    step(0, 6'h2B, 1, FE, C_FETCH_RDY, 8'd2, 0);
    step(0, 6'h2B, 1, DE, C_DECODE,    8'd2, 0);
    step(0, 6'h2B, 0, MA, C_MEM_ADDR,  8'd2, 0);
    step(0, 6'h2B, 0, WR, C_MEM_WR,    8'd2, 0);
    step(0, 6'h2B, 0, WR, C_MEM_WR,    8'd2, 0);
    step(0, 6'h2B, 1, WR, C_MEM_WR,    8'd2, 0);

    // beq, j, addi
    step(0, 6'h04, 1, FE, C_FETCH_RDY, 8'd3, 0);
    step(0, 6'h04, 1, DE, C_DECODE,    8'd3, 0);
    step(0, 6'h04, 1, BR, C_BRANCH,    8'd3, 0);
    step(0, 6'h02, 1, FE, C_FETCH_RDY, 8'd4, 0);
    step(0, 6'h02, 1, DE, C_DECODE,    8'd4, 0);
    step(0, 6'h02, 1, JP, C_JUMP,      8'd4, 0);
    step(0, 6'h08, 1, FE, C_FETCH_RDY, 8'd5, 0);
    step(0, 6'h08, 1, DE, C_DECODE,    8'd5, 0);
    step(0, 6'h08, 1, IX, C_I_EXEC,    8'd5, 0);
    step(0, 6'h08, 1, IW, C_I_WB,      8'd5, 0);

    // MemReady arrives in the 4th FETCH cycle: it beats the timeout
    for (int i = 0; i < 3; i++) step(0, 6'h00, 0, FE, C_FETCH_WAIT, 8'd6, 0);
    step(0, 6'h00, 1, FE, C_FETCH_RDY, 8'd6, 0);
    step(0, 6'h00, 1, DE, C_DECODE,    8'd6, 0);
    step(0, 6'h00, 1, RX, C_R_EXEC,    8'd6, 0);
    step(0, 6'h00, 1, RW, C_R_WB,      8'd6, 0);

    // Reset while waiting in MEM_RD
    step(0, 6'h23, 1, FE, C_FETCH_RDY, 8'd7, 0);
    step(0, 6'h23, 1, DE, C_DECODE,    8'd7, 0);
    step(0, 6'h23, 0, MA, C_MEM_ADDR,  8'd7, 0);
    step(1, 6'h23, 0, MR, C_MEM_RD,    8'd7, 0);

    // Fresh FETCH with MemReady stuck low: HALT after 4 FETCH cycles
    for (int i = 0; i < 4; i++) step(0, 6'h00, 0, FE, C_FETCH_WAIT, 8'd0, 0);
    step(0, 6'h00, 0, HT, C_HALT, 8'd0, 1);
    step(0, 6'h00, 1, HT, C_HALT, 8'd0, 1);
    step(1, 6'h00, 0, HT, C_HALT, 8'd0, 1);

    // Illegal opcode: HALT after DECODE, held 20 cycles until Reset
    step(0, 6'h00, 1, FE, C_FETCH_RDY, 8'd0, 0);
    step(0, 6'h3F, 1, DE, C_DECODE,    8'd0, 0);
    for (int i = 0; i < 20; i++) step(0, 6'h3F, 1'(i % 2), HT, C_HALT, 8'd0, 1);
    step(1, 6'h3F, 1, HT, C_HALT, 8'd0, 1);
    step(0, 6'h00, 0, FE, C_FETCH_WAIT, 8'd0, 0);

    @(negedge Clk);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
